// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..MaxDataBits data bits LSB first,
// none/even/odd parity and 1/1.5/2 stop bits, paced by an external oversample tick.
module uart_tx_cfg #(
  parameter int MaxDataBits = 9,
  parameter int Oversample  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sample_tick_i,
  input  logic [3:0]             data_len_i,
  input  logic [1:0]             parity_i,
  input  logic [1:0]             stop_i,
  input  logic [MaxDataBits-1:0] din_i,
  input  logic                   din_valid_i,
  output logic                   din_ready_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   tx_done_tick_o
);

  localparam int              CntW       = $clog2(2 * Oversample);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] BitLast    = CntW'(Oversample - 1);
  localparam logic [CntW-1:0] Stop15Last = CntW'(3 * Oversample / 2 - 1);
  localparam logic [CntW-1:0] Stop2Last  = CntW'(2 * Oversample - 1);
  localparam logic [3:0]      MaxLen     = 4'(MaxDataBits);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [3:0]             bits_q;
  logic [3:0]             len_q;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic [CntW-1:0]        stop_last_q;
  logic [MaxDataBits-1:0] buf_q;
  logic                   tx_q;

  logic [3:0]             len_d;
  logic [MaxDataBits-1:0] data_d;
  logic                   par_en_d;
  logic                   par_bit_d;
  logic [CntW-1:0]        stop_last_d;
  logic                   bit_end;
  logic                   stop_end;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'd5) return 4'd5;
    if (len > MaxLen) return MaxLen;
    return len;
  endfunction

  function automatic logic [MaxDataBits-1:0] mask_data(input logic [MaxDataBits-1:0] d,
                                                       input logic [3:0]             len);
    logic [MaxDataBits-1:0] m;
    for (int i = 0; i < MaxDataBits; i++) m[i] = (i < int'(len));
    return d & m;
  endfunction

  // Frame configuration snapshotted on the accept edge
  always_comb begin
    len_d     = clamp_len(data_len_i);
    data_d    = mask_data(din_i, len_d);
    par_en_d  = (parity_i == 2'b01) || (parity_i == 2'b10);
    par_bit_d = (parity_i == 2'b10) ? ~^data_d : ^data_d;
    case (stop_i)
      2'b00:   stop_last_d = BitLast;
      2'b01:   stop_last_d = Stop15Last;
      default: stop_last_d = Stop2Last;
    endcase
  end

  assign bit_end  = sample_tick_i && (cnt_q == BitLast);
  assign stop_end = sample_tick_i && (cnt_q == stop_last_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      len_q       <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_last_q <= '0;
      buf_q       <= '0;
      tx_q        <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (din_valid_i) begin
            state_q     <= S_START;
            tx_q        <= 1'b0;
            cnt_q       <= '0;
            bits_q      <= '0;
            buf_q       <= data_d;
            len_q       <= len_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop_last_q <= stop_last_d;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= buf_q[0];
          end else if (sample_tick_i) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q  <= '0;
            buf_q  <= buf_q >> 1;
            bits_q <= bits_q + 4'd1;
            if (bits_q == len_q - 4'd1) begin
              if (par_en_q) begin
                state_q <= S_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              // buf_q[1] is the bit that lands in position 0 after this shift
              tx_q <= buf_q[1];
            end
          end else if (sample_tick_i) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else if (sample_tick_i) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (sample_tick_i) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign tx_done_tick_o = (state_q == S_STOP) && stop_end;
  assign tx_o           = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, length clamping, back-to-back
// handshake and mid-frame reset, with an oversample tick every 4 clocks.
module tb_uart_tx_cfg;

  localparam int MaxDataBits = 9;
  localparam int Oversample  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   tick = 1'b0;
  logic [3:0]             data_len;
  logic [1:0]             parity;
  logic [1:0]             stop;
  logic [MaxDataBits-1:0] din;
  logic                   din_valid;
  logic                   din_ready;
  logic                   tx;
  logic                   busy;
  logic                   done_tick;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  logic [1:0] tdiv = 2'd0;

  uart_tx_cfg #(
    .MaxDataBits(MaxDataBits),
    .Oversample (Oversample)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_tick_i (tick),
    .data_len_i    (data_len),
    .parity_i      (parity),
    .stop_i        (stop),
    .din_i         (din),
    .din_valid_i   (din_valid),
    .din_ready_o   (din_ready),
    .tx_o          (tx),
    .busy_o        (busy),
    .tx_done_tick_o(done_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tdiv <= tdiv + 2'd1;
    tick <= (tdiv == 2'd3);
  end

  always @(posedge clk) begin
    if (busy && tick) tick_cnt <= tick_cnt + 1;
    if (done_tick) done_cnt <= done_cnt + 1;
  end

  task automatic start_word(input logic [8:0] d, input logic [3:0] len,
                            input logic [1:0] par, input logic [1:0] stp);
    @(negedge clk);
    din = d; data_len = len; parity = par; stop = stp; din_valid = 1'b1;
  endtask

  // Waits for the accept edge, then follows the frame until busy drops.
  // exp holds the frame bits with the start bit in position 0.
  task automatic check_frame(input string name, input logic [11:0] exp, input int nbits,
                             input int stop_ticks, input bit drop, output int waited);
    logic [11:0] got;
    int t0, d0, t, cyc;
    bit stop_ok, ready_ok, ok;
    got = '0; stop_ok = 1'b1; ready_ok = 1'b1; waited = 0; ok = 1'b0; cyc = 0;
    while (!ok && waited < 200) begin
      @(posedge clk);
      waited++;
      ok = din_valid && din_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s accept: no accept after %0d clks, required within 200", name, waited);
      return;
    end
    #1;
    if (drop) begin
      din_valid = 1'b0; din = ~din; data_len = 4'd5; parity = 2'b01; stop = 2'b00;
    end
    t0 = tick_cnt; d0 = done_cnt;
    while (busy && cyc < 4000) begin
      t = tick_cnt - t0;
      if (t < Oversample * nbits) got[t / Oversample] = tx;
      else if (tx !== 1'b1) stop_ok = 1'b0;
      if (din_ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s end: busy still high after %0d clks", name, cyc);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s bits: got %h required %h", name, got, exp);
    end
    checks++;
    if (tick_cnt - t0 !== Oversample * nbits + stop_ticks) begin
      errors++;
      $display("FAIL %s ticks: got %0d required %0d", name, tick_cnt - t0,
               Oversample * nbits + stop_ticks);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses required 1", name, done_cnt - d0);
    end
    checks++;
    if (!stop_ok || tx !== 1'b1) begin
      errors++;
      $display("FAIL %s stop: line low during stop/after frame, tx now %b required 1", name, tx);
    end
    checks++;
    if (!ready_ok) begin
      errors++;
      $display("FAIL %s ready: din_ready_o high mid-frame, required 0", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0; din = '0; data_len = 4'd8; parity = 2'b00; stop = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b required 1", tx); end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b required 1", din_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++;
    if (done_tick !== 1'b0) begin errors++; $display("FAIL reset done: got %b required 0", done_tick); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL idle ticks: busy %b tx %b required 0/1", busy, tx);
    end
  endtask

  task automatic test_formats();
    int w;
    start_word(9'h0A5, 4'd8, 2'b00, 2'b00);
    check_frame("8N1_A5", 12'h14A, 9, 16, 1'b1, w);
    start_word(9'h041, 4'd7, 2'b01, 2'b00);
    check_frame("7E1_41", 12'h082, 9, 16, 1'b1, w);
    start_word(9'h041, 4'd7, 2'b10, 2'b10);
    check_frame("7O2_41", 12'h182, 9, 32, 1'b1, w);
    start_word(9'h1FF, 4'd5, 2'b00, 2'b01);
    check_frame("5N15_1FF", 12'h03E, 6, 24, 1'b1, w);
    start_word(9'h100, 4'd9, 2'b11, 2'b00);
    check_frame("9N1_100", 12'h200, 10, 16, 1'b1, w);
  endtask

  task automatic test_len_clamp();
    int w;
    start_word(9'h0EA, 4'd3, 2'b00, 2'b00);
    check_frame("len3", 12'h014, 6, 16, 1'b1, w);
    start_word(9'h155, 4'd12, 2'b01, 2'b11);
    check_frame("len12_E2", 12'h6AA, 11, 32, 1'b1, w);
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    start_word(9'h03C, 4'd8, 2'b00, 2'b00);
    fork
      begin
        check_frame("b2b_first", 12'h078, 9, 16, 1'b0, w1);
        check_frame("b2b_second", 12'h0DA, 8, 16, 1'b0, w2);
      end
      begin
        @(posedge busy);
        @(negedge clk);
        din = 9'h02D; data_len = 4'd6; parity = 2'b10; stop = 2'b00;
        @(negedge busy);
        @(posedge busy);
        @(negedge clk);
        din_valid = 1'b0; din = 9'h1FF; data_len = 4'd5; parity = 2'b01; stop = 2'b10;
      end
    join
    checks++;
    if (w2 !== 1) begin
      errors++;
      $display("FAIL b2b gap: got %0d idle clks required 1", w2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int waited, d0, w;
    bit ok;
    waited = 0; ok = 1'b0;
    start_word(9'h0FF, 4'd8, 2'b00, 2'b00);
    while (!ok && waited < 200) begin
      @(posedge clk);
      waited++;
      ok = din_valid && din_ready;
    end
    #1;
    din_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: tx %b busy %b required 1/0", tx, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt !== d0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: busy %b tx %b done pulses %0d required 0/1/0", busy, tx, done_cnt - d0);
    end
    start_word(9'h013, 4'd5, 2'b01, 2'b00);
    check_frame("rst_next_5E1", 12'h066, 7, 16, 1'b1, w);
  endtask

  initial begin
    test_reset();
    test_formats();
    test_len_clamp();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
